// File: rtl/mul1234_scheduler_if.sv
// Request/response bundle for the shared-adder multiplier scheduler:
// two valid/ready requesters and one tagged valid/ready response channel.
interface mul1234_scheduler_if #(parameter int DW = 8);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_a;
    logic [4:0]    req0_m;
    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_a;
    logic [4:0]    req1_m;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW+1:0] resp_o;
    logic          resp_id;
    logic          resp_err;

    modport master (
        output req0_valid, req0_a, req0_m,
        input  req0_ready,
        output req1_valid, req1_a, req1_m,
        input  req1_ready,
        input  resp_valid, resp_o, resp_id, resp_err,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_m,
        output req0_ready,
        input  req1_valid, req1_a, req1_m,
        output req1_ready,
        output resp_valid, resp_o, resp_id, resp_err,
        input  resp_ready
    );
endinterface

// File: rtl/mul1234_scheduler.sv
// Time-shared multiply-by-0..4: round-robin picks a requester, then a single
// ripple adder accumulates the operand k times before a tagged response.
module mul1234_scheduler #(
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mul1234_scheduler_if.slave   bus
);
    localparam int RW = DW + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_r;
    logic [RW-1:0] acc_r;
    logic [RW-1:0] a_r;
    logic [RW-1:0] resp_o_r;
    logic [2:0]    count_r;
    logic          ptr_r;
    logic          resp_valid_r;
    logic          resp_id_r;
    logic          resp_err_r;

    logic          grant0_s;
    logic          grant1_s;
    logic          hs0_s;
    logic          hs1_s;
    logic [DW-1:0] sel_a_s;
    logic [4:0]    sel_m_s;
    logic [2:0]    sel_k_s;
    logic          sel_bad_s;
    logic [RW-1:0] sum_s;

    // Bit-serial carry chain; the final carry is dropped since 4 x max operand fits in RW bits.
    function automatic logic [RW-1:0] ripple_add(input logic [RW-1:0] x,
                                                  input logic [RW-1:0] y,
                                                  input logic          cin);
        logic          c;
        logic [RW-1:0] s;
        c = cin;
        for (int i = 0; i < RW; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return s;
    endfunction

    function automatic logic [2:0] decode_k(input logic [4:0] m);
        logic [2:0] k;
        case (m)
            5'b00001: k = 3'd0;
            5'b00010: k = 3'd1;
            5'b00100: k = 3'd2;
            5'b01000: k = 3'd3;
            5'b10000: k = 3'd4;
            default:  k = 3'd0;
        endcase
        return k;
    endfunction

    function automatic logic not_onehot(input logic [4:0] m);
        logic [2:0] ones;
        ones = 3'd0;
        for (int i = 0; i < 5; i++) begin
            ones = ones + {2'b00, m[i]};
        end
        return (ones != 3'd1);
    endfunction

    // Arbitration, request selection and the one shared adder.
    always_comb begin
        grant0_s  = bus.req0_valid && (!bus.req1_valid || !ptr_r);
        grant1_s  = bus.req1_valid && (!bus.req0_valid || ptr_r);
        hs0_s     = !rst && (state_r == IDLE) && grant0_s;
        hs1_s     = !rst && (state_r == IDLE) && grant1_s;
        if (hs1_s) begin
            sel_a_s = bus.req1_a;
            sel_m_s = bus.req1_m;
        end else begin
            sel_a_s = bus.req0_a;
            sel_m_s = bus.req0_m;
        end
        sel_k_s   = decode_k(sel_m_s);
        sel_bad_s = not_onehot(sel_m_s);
        sum_s     = ripple_add(acc_r, a_r, 1'b0);
    end

    assign bus.req0_ready = hs0_s;
    assign bus.req1_ready = hs1_s;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_o     = resp_o_r;
    assign bus.resp_id    = resp_id_r;
    assign bus.resp_err   = resp_err_r;

    // Control FSM with accumulator, response registers and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            acc_r        <= {RW{1'b0}};
            a_r          <= {RW{1'b0}};
            resp_o_r     <= {RW{1'b0}};
            count_r      <= 3'd0;
            ptr_r        <= 1'b0;
            resp_valid_r <= 1'b0;
            resp_id_r    <= 1'b0;
            resp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (hs0_s || hs1_s) begin
                        a_r        <= {2'b00, sel_a_s};
                        resp_id_r  <= hs1_s;
                        acc_r      <= {RW{1'b0}};
                        resp_o_r   <= {RW{1'b0}};
                        resp_err_r <= sel_bad_s;
                        if (sel_bad_s || (sel_k_s == 3'd0)) begin
                            count_r      <= 3'd0;
                            resp_valid_r <= 1'b1;
                            state_r      <= DONE;
                        end else begin
                            count_r <= sel_k_s;
                            state_r <= ADD;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ADD: begin
                    acc_r   <= sum_s;
                    count_r <= count_r - 3'd1;
                    // The addition finishing now is the last one.
                    if (count_r == 3'd1) begin
                        resp_o_r     <= sum_s;
                        resp_valid_r <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        state_r <= ADD;
                    end
                end
                DONE: begin
                    if (bus.resp_ready) begin
                        resp_valid_r <= 1'b0;
                        ptr_r        <= ~resp_id_r;
                        state_r      <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    resp_valid_r <= 1'b0;
                    state_r      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mul1234_scheduler.sv
// Directed self-checking bench for mul1234_scheduler; each task drives one
// scenario and compares DUT outputs against hand-computed values.
module tb_mul1234_scheduler;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    mul1234_scheduler_if #(.DW(8)) bus ();

    mul1234_scheduler #(.DW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = 8'd0; bus.req0_m = 5'd0;
        bus.req1_valid = 1'b0; bus.req1_a = 8'd0; bus.req1_m = 5'd0;
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.resp_o !== 10'd0) begin
            bad++; $display("FAIL reset_idle: resp_valid=%b resp_o=%0d want 0 0", bus.resp_valid, bus.resp_o);
        end
        // Start a x2 request, then reset asynchronously while it sits in DONE.
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd10; bus.req0_m = 5'b00100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (bus.resp_valid !== 1'b1 || bus.resp_o !== 10'd20) begin
            bad++; $display("FAIL pre_reset_resp: valid=%b o=%0d want 1 20", bus.resp_valid, bus.resp_o);
        end
        #3;
        rst = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.resp_o !== 10'd0 || bus.resp_id !== 1'b0 ||
            bus.resp_err !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL async_reset: valid=%b o=%0d id=%b err=%b r0=%b r1=%b want all 0",
                            bus.resp_valid, bus.resp_o, bus.resp_id, bus.resp_err, bus.req0_ready, bus.req1_ready);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL reset_priority: r0=%b r1=%b want 1 0", bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int cyc;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd200; bus.req0_m = 5'b10000;
        #1;
        total++;
        if (bus.req0_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready: got %b want 1", bus.req0_ready);
        end
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        total++;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL single_ready_in_add: r0=%b r1=%b want 0 0", bus.req0_ready, bus.req1_ready);
        end
        cyc = 1;
        while (bus.resp_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc != 5 || bus.resp_o !== 10'd800 || bus.resp_id !== 1'b0 || bus.resp_err !== 1'b0) begin
            bad++; $display("FAIL single_x4: cyc=%0d o=%0d id=%b err=%b want 5 800 0 0",
                            cyc, bus.resp_o, bus.resp_id, bus.resp_err);
        end
        @(posedge clk); #1;
        total++;
        if (bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL single_consume: resp_valid=%b want 0", bus.resp_valid);
        end
    endtask

    task automatic test_zero_invalid();
        logic [7:0] a_tab [3];
        logic [4:0] m_tab [3];
        logic       e_tab [3];
        a_tab[0] = 8'd99;  m_tab[0] = 5'b00001; e_tab[0] = 1'b0;
        a_tab[1] = 8'd77;  m_tab[1] = 5'b00110; e_tab[1] = 1'b1;
        a_tab[2] = 8'd55;  m_tab[2] = 5'b00000; e_tab[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = a_tab[i]; bus.req0_m = m_tab[i];
            @(posedge clk); #1;
            bus.req0_valid = 1'b0;
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_o !== 10'd0 || bus.resp_err !== e_tab[i]) begin
                bad++; $display("FAIL zero_invalid[%0d]: valid=%b o=%0d err=%b want 1 0 %b",
                                i, bus.resp_valid, bus.resp_o, bus.resp_err, e_tab[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        bus.resp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd50; bus.req1_m = 5'b00100;
        @(posedge clk); #1;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd1; bus.req0_m = 5'b00010;
        cyc = 1;
        while (bus.resp_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc != 3) begin
            bad++; $display("FAIL bp_latency: cyc=%0d want 3", cyc);
        end
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.resp_valid !== 1'b1 || bus.resp_o !== 10'd100 || bus.resp_id !== 1'b1 ||
                bus.resp_err !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
                bad++; $display("FAIL bp_hold[%0d]: v=%b o=%0d id=%b err=%b r0=%b r1=%b want 1 100 1 0 0 0",
                                i, bus.resp_valid, bus.resp_o, bus.resp_id, bus.resp_err, bus.req0_ready, bus.req1_ready);
            end
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (bus.resp_valid !== 1'b0) begin
            bad++; $display("FAIL bp_consume: resp_valid=%b want 0", bus.resp_valid);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int cyc;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd255; bus.req0_m = 5'b01000;
        bus.req1_valid = 1'b1; bus.req1_a = 8'd17;  bus.req1_m = 5'b00100;
        for (int i = 0; i < 4; i++) begin
            cyc = 0;
            while (bus.resp_valid !== 1'b1 && cyc < 15) begin
                @(posedge clk); #1;
                cyc++;
            end
            total++;
            if ((i % 2) == 0) begin
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b0 || bus.resp_o !== 10'd765) begin
                    bad++; $display("FAIL rr[%0d]: v=%b id=%b o=%0d want 1 0 765", i, bus.resp_valid, bus.resp_id, bus.resp_o);
                end
            end else begin
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== 1'b1 || bus.resp_o !== 10'd34) begin
                    bad++; $display("FAIL rr[%0d]: v=%b id=%b o=%0d want 1 1 34", i, bus.resp_valid, bus.resp_id, bus.resp_o);
                end
            end
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        if (bus.resp_valid === 1'b1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_add();
        int cyc;
        int seen;
        bus.req0_valid = 1'b1; bus.req0_a = 8'd100; bus.req0_m = 5'b10000;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        #1;
        total++;
        if (bus.resp_valid !== 1'b0 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            bad++; $display("FAIL mid_add_reset: v=%b r0=%b r1=%b want 0 0 0", bus.resp_valid, bus.req0_ready, bus.req1_ready);
        end
        bus.req0_valid = 1'b0;
        #2;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid !== 1'b0) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++; $display("FAIL mid_add_no_resp: resp_valid seen %0d cycles want 0", seen);
        end
        bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_m = 5'b10000;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        cyc = 1;
        while (bus.resp_valid !== 1'b1 && cyc < 12) begin
            @(posedge clk); #1;
            cyc++;
        end
        total++;
        if (cyc != 5 || bus.resp_o !== 10'd12 || bus.resp_id !== 1'b0 || bus.resp_err !== 1'b0) begin
            bad++; $display("FAIL fresh_after_reset: cyc=%0d o=%0d id=%b err=%b want 5 12 0 0",
                            cyc, bus.resp_o, bus.resp_id, bus.resp_err);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single();
        test_zero_invalid();
        test_backpressure();
        test_round_robin();
        test_reset_mid_add();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
